// File: rtl/axi_ad9364_dac_sched_pkg.sv
// Shared encodings for the AD9364 DAC sample-port scheduler: source select, FSM states and
// the built-in test pattern samples.
package axi_ad9364_dac_sched_pkg;

  typedef enum logic [1:0] {
    SrcS0   = 2'd0,
    SrcS1   = 2'd1,
    SrcPat  = 2'd2,
    SrcZero = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam int unsigned PatSteps = 3;

  localparam logic [11:0] PatI0 = 12'h7FF;
  localparam logic [11:0] PatQ0 = 12'h7DF;
  localparam logic [11:0] PatI1 = 12'h000;
  localparam logic [11:0] PatQ1 = 12'h3DF;
  localparam logic [11:0] PatI2 = 12'h800;
  localparam logic [11:0] PatQ2 = 12'h000;

endpackage

// File: rtl/axi_ad9364_dac_sched_if.sv
// Sample streams from the two requesters and the DAC sample port, as seen by the scheduler.
interface axi_ad9364_dac_sched_if #(
  parameter int unsigned DATA_WIDTH = 12
);

  logic                    s0_valid;
  logic                    s0_ready;
  logic [4*DATA_WIDTH-1:0] s0_data;
  logic                    s1_valid;
  logic                    s1_ready;
  logic [4*DATA_WIDTH-1:0] s1_data;

  logic                    dac_valid;
  logic [DATA_WIDTH-1:0]   dac_data_i1;
  logic [DATA_WIDTH-1:0]   dac_data_q1;
  logic [DATA_WIDTH-1:0]   dac_data_i2;
  logic [DATA_WIDTH-1:0]   dac_data_q2;
  logic                    dac_r1_mode;

  modport master (
    output s0_valid, s0_data, s1_valid, s1_data,
    input  s0_ready, s1_ready,
    input  dac_valid, dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, dac_r1_mode
  );

  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data,
    output s0_ready, s1_ready,
    output dac_valid, dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, dac_r1_mode
  );

endinterface

// File: rtl/axi_ad9364_dac_patgen.sv
// Three-step I/Q test pattern sequencer; only instantiated when AXI_AD9364_DAC_SCHED_PATGEN_EN
// is defined.
module axi_ad9364_dac_patgen
  import axi_ad9364_dac_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  advance_i,
  output logic [DATA_WIDTH-1:0] sample_i_o,
  output logic [DATA_WIDTH-1:0] sample_q_o
);

  localparam logic [1:0] IdxLast = 2'(PatSteps - 1);

  logic [1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (advance_i) begin
      idx_d = (idx_q == IdxLast) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  always_comb begin
    sample_i_o = DATA_WIDTH'(PatI0);
    sample_q_o = DATA_WIDTH'(PatQ0);
    case (idx_q)
      2'd1: begin
        sample_i_o = DATA_WIDTH'(PatI1);
        sample_q_o = DATA_WIDTH'(PatQ1);
      end
      2'd2: begin
        sample_i_o = DATA_WIDTH'(PatI2);
        sample_q_o = DATA_WIDTH'(PatQ2);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/axi_ad9364_dac_sched.sv
// AD9364 DAC sample-port scheduler: time-shares the port between s0, s1, zeros and (with
// AXI_AD9364_DAC_SCHED_PATGEN_EN defined) a built-in pattern, strobing dac_valid every RATE_DIV.
module axi_ad9364_dac_sched
  import axi_ad9364_dac_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 12,
  parameter int unsigned RATE_DIV        = 2,
  parameter int unsigned UFLOW_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       cfg_enable,
  input  logic [1:0]                 cfg_src,
  input  logic                       cfg_r1_mode,
  input  logic                       cfg_uflow_hold,
  axi_ad9364_dac_sched_if.slave      bus,
  output logic                       status_active,
  output logic [UFLOW_CNT_WIDTH-1:0] status_uflow_cnt
);

  localparam int unsigned DivW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [DivW-1:0]            DivLast = DivW'(RATE_DIV - 1);
  localparam logic [DivW-1:0]            DivOne  = DivW'(1);
  localparam logic [UFLOW_CNT_WIDTH-1:0] UcntOne = UFLOW_CNT_WIDTH'(1);
  localparam int unsigned SmpW = 4 * DATA_WIDTH;

  state_e                     state_q, state_d;
  logic [DivW-1:0]            div_q, div_d;
  logic                       r1_q, r1_d;
  logic                       valid_q, valid_d;
  logic [SmpW-1:0]            data_q, data_d;
  logic [UFLOW_CNT_WIDTH-1:0] ucnt_q, ucnt_d;
  logic [SmpW-1:0]            smp;
  logic                       uflow;
  logic                       tick;

`ifdef AXI_AD9364_DAC_SCHED_PATGEN_EN
  logic                  pat_clear, pat_adv;
  logic [DATA_WIDTH-1:0] pat_i, pat_q;

  axi_ad9364_dac_patgen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_patgen (
    .clk_i     (clk),
    .rst_ni    (rstn),
    .clear_i   (pat_clear),
    .advance_i (pat_adv),
    .sample_i_o(pat_i),
    .sample_q_o(pat_q)
  );
`endif

  assign tick = (state_q != StIdle) && (div_q == DivLast);

  always_comb begin
    state_d      = state_q;
    div_d        = '0;
    r1_d         = r1_q;
    valid_d      = 1'b0;
    data_d       = data_q;
    ucnt_d       = ucnt_q;
    smp          = '0;
    uflow        = 1'b0;
    bus.s0_ready = 1'b0;
    bus.s1_ready = 1'b0;
`ifdef AXI_AD9364_DAC_SCHED_PATGEN_EN
    pat_clear    = 1'b0;
    pat_adv      = 1'b0;
`endif

    if ((state_q != StIdle) && !tick) begin
      div_d = div_q + DivOne;
    end

    unique case (state_q)
      StIdle: begin
        if (cfg_enable) begin
          state_d = StRun;
          r1_d    = cfg_r1_mode;
`ifdef AXI_AD9364_DAC_SCHED_PATGEN_EN
          pat_clear = 1'b1;
`endif
        end
      end
      StRun: begin
        if (tick) begin
          valid_d = 1'b1;
          unique case (src_e'(cfg_src))
            SrcS0: begin
              if (bus.s0_valid) begin
                bus.s0_ready = 1'b1;
                smp          = bus.s0_data;
              end else begin
                uflow = 1'b1;
              end
            end
            SrcS1: begin
              if (bus.s1_valid) begin
                bus.s1_ready = 1'b1;
                smp          = bus.s1_data;
              end else begin
                uflow = 1'b1;
              end
            end
`ifdef AXI_AD9364_DAC_SCHED_PATGEN_EN
            SrcPat: begin
              smp     = {pat_i, pat_q, pat_i, pat_q};
              pat_adv = 1'b1;
            end
            SrcZero: smp = '0;
`else
            SrcPat, SrcZero: smp = '0;
`endif
            default: smp = '0;
          endcase
        end
        // A falling enable on a tick still lets that tick be serviced above.
        if (!cfg_enable) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (tick) begin
          valid_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (uflow) begin
      smp = cfg_uflow_hold ? data_q : '0;
      if (ucnt_q != '1) begin
        ucnt_d = ucnt_q + UcntOne;
      end
    end

    // One-channel mode drops the second I/Q pair, including any held sample.
    if (r1_q) begin
      smp[2*DATA_WIDTH-1:0] = '0;
    end

    if (valid_d) begin
      data_d = smp;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      div_q   <= '0;
      r1_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      r1_q    <= r1_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign bus.dac_valid   = valid_q;
  assign bus.dac_data_i1 = data_q[4*DATA_WIDTH-1 -: DATA_WIDTH];
  assign bus.dac_data_q1 = data_q[3*DATA_WIDTH-1 -: DATA_WIDTH];
  assign bus.dac_data_i2 = data_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign bus.dac_data_q2 = data_q[DATA_WIDTH-1 -: DATA_WIDTH];
  assign bus.dac_r1_mode = r1_q;
  assign status_active    = (state_q != StIdle);
  assign status_uflow_cnt = ucnt_q;

endmodule

// File: tb/tb_axi_ad9364_dac_sched.sv
// Bench for the DAC scheduler: a tick-arithmetic reference model checked every cycle, plus
// directed scenarios with literal expected samples and counts.
module tb_axi_ad9364_dac_sched;

  localparam int unsigned DW   = 12;
  localparam int unsigned RD   = 2;
  localparam int unsigned UCW  = 4;
  localparam int          UMAX = (1 << UCW) - 1;
`ifdef AXI_AD9364_DAC_SCHED_PATGEN_EN
  localparam bit PAT_ON = 1'b1;
`else
  localparam bit PAT_ON = 1'b0;
`endif

  logic           clk  = 1'b0;
  logic           rstn = 1'b1;
  logic           cfg_enable;
  logic [1:0]     cfg_src;
  logic           cfg_r1_mode;
  logic           cfg_uflow_hold;
  logic           status_active;
  logic [UCW-1:0] status_uflow_cnt;

  axi_ad9364_dac_sched_if #(.DATA_WIDTH(DW)) bus ();

  axi_ad9364_dac_sched #(
    .DATA_WIDTH     (DW),
    .RATE_DIV       (RD),
    .UFLOW_CNT_WIDTH(UCW)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .cfg_enable      (cfg_enable),
    .cfg_src         (cfg_src),
    .cfg_r1_mode     (cfg_r1_mode),
    .cfg_uflow_hold  (cfg_uflow_hold),
    .bus             (bus),
    .status_active   (status_active),
    .status_uflow_cnt(status_uflow_cnt)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: ticks fall every RD cycles counted from the first RUN cycle.
  logic [11:0] pat_i [3] = '{12'h7FF, 12'h000, 12'h800};
  logic [11:0] pat_q [3] = '{12'h7DF, 12'h3DF, 12'h000};
  bit          m_run, m_flush, m_r1, m_valid;
  int          m_t, m_pat, m_ucnt;
  logic [47:0] m_data;
  logic [47:0] dac_log [$];
  int          r0_cnt = 0;
  int          r1_cnt = 0;

  initial begin : model
    bit          tick, e_r0, e_r1, nv;
    logic [47:0] nd;
    logic [47:0] dac_now;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_run = 0; m_flush = 0; m_r1 = 0; m_valid = 0;
        m_t = 0; m_pat = 0; m_ucnt = 0; m_data = '0;
      end
      tick = (m_run || m_flush) && ((m_t % RD) == (RD - 1));
      e_r0 = m_run && tick && (cfg_src == 2'd0) && bus.s0_valid;
      e_r1 = m_run && tick && (cfg_src == 2'd1) && bus.s1_valid;
      dac_now = {bus.dac_data_i1, bus.dac_data_q1, bus.dac_data_i2, bus.dac_data_q2};

      chk("dac_valid", 64'(bus.dac_valid), 64'(m_valid));
      chk("dac_data", 64'(dac_now), 64'(m_data));
      chk("s0_ready", 64'(bus.s0_ready), 64'(e_r0));
      chk("s1_ready", 64'(bus.s1_ready), 64'(e_r1));
      chk("status_active", 64'(status_active), 64'(m_run || m_flush));
      chk("dac_r1_mode", 64'(bus.dac_r1_mode), 64'(m_r1));
      chk("uflow_cnt", 64'(status_uflow_cnt), 64'(m_ucnt));

      if (bus.dac_valid) dac_log.push_back(dac_now);
      if (bus.s0_ready) r0_cnt++;
      if (bus.s1_ready) r1_cnt++;

      if (rstn) begin
        nv = 1'b0;
        nd = m_data;
        if (m_run && tick) begin
          nv = 1'b1;
          case (cfg_src)
            2'd0, 2'd1: begin
              if (cfg_src == 2'd0 ? bus.s0_valid : bus.s1_valid) begin
                nd = (cfg_src == 2'd0) ? bus.s0_data : bus.s1_data;
              end else begin
                nd = cfg_uflow_hold ? m_data : 48'h0;
                m_ucnt = (m_ucnt < UMAX) ? m_ucnt + 1 : UMAX;
              end
            end
            2'd2: begin
              nd = PAT_ON ? {pat_i[m_pat], pat_q[m_pat], pat_i[m_pat], pat_q[m_pat]} : 48'h0;
              m_pat = (m_pat + 1) % 3;
            end
            default: nd = 48'h0;
          endcase
          if (m_r1) nd[23:0] = '0;
        end else if (m_flush && tick) begin
          nv = 1'b1;
          nd = 48'h0;
        end

        if (!m_run && !m_flush) begin
          if (cfg_enable) begin
            m_run = 1; m_t = 0; m_r1 = cfg_r1_mode; m_pat = 0;
          end
        end else if (m_flush && tick) begin
          m_flush = 0;
        end else begin
          if (m_run && !cfg_enable) begin
            m_run = 0; m_flush = 1;
          end
          m_t++;
        end
        m_valid = nv;
        m_data  = nd;
      end
    end
  end

  logic [47:0] exp_pat [3];
  logic [47:0] smp_a, smp_b, smp_h;
  int base, r0_base, r1_base;

  initial begin
    rstn = 1'b0;
    cfg_enable = 0; cfg_src = 2'd0; cfg_r1_mode = 0; cfg_uflow_hold = 0;
    bus.s0_valid = 0; bus.s0_data = '0; bus.s1_valid = 0; bus.s1_data = '0;
    smp_a = 48'h123_456_789_ABC;
    smp_b = 48'hFED_CBA_987_654;
    smp_h = 48'hABC_123_456_789;
    exp_pat[0] = PAT_ON ? 48'h7FF_7DF_000_000 : 48'h0;
    exp_pat[1] = PAT_ON ? 48'h000_3DF_000_000 : 48'h0;
    exp_pat[2] = PAT_ON ? 48'h800_000_000_000 : 48'h0;

    step(3);
    chk("reset_dac_valid", 64'(bus.dac_valid), 64'd0);
    chk("reset_active", 64'(status_active), 64'd0);
    chk("reset_uflow", 64'(status_uflow_cnt), 64'd0);
    rstn = 1'b1;
    step(2);

    // s0 streaming at full cadence
    cfg_src = 2'd0; bus.s0_valid = 1; bus.s0_data = smp_a; cfg_enable = 1;
    base = dac_log.size(); r0_base = r0_cnt;
    step(12);
    chk("t1_strobes", 64'(dac_log.size() - base), 64'd5);
    chk("t1_readies", 64'(r0_cnt - r0_base), 64'd5);
    chk("t1_sample", 64'(dac_log[base]), 64'(smp_a));
    chk("t1_uflow", 64'(status_uflow_cnt), 64'd0);

    // s1 starved, zero fill
    cfg_src = 2'd1; bus.s1_valid = 0; cfg_uflow_hold = 0;
    base = dac_log.size(); r0_base = r0_cnt;
    step(6);
    chk("t2_strobes", 64'(dac_log.size() - base), 64'd3);
    chk("t2_zero", 64'(dac_log[base + 2]), 64'd0);
    chk("t2_uflow", 64'(status_uflow_cnt), 64'd3);
    chk("t2_s0_quiet", 64'(r0_cnt - r0_base), 64'd0);

    // hold policy repeats the last sample
    bus.s1_valid = 1; bus.s1_data = smp_h;
    base = dac_log.size();
    step(2);
    bus.s1_valid = 0; cfg_uflow_hold = 1;
    step(4);
    chk("t3_strobes", 64'(dac_log.size() - base), 64'd3);
    chk("t3_held_iq1", 64'(dac_log[base + 2][47:24]), 64'h000000ABC123);
    chk("t3_held_all", 64'(dac_log[base + 1]), 64'(smp_h));
    chk("t3_uflow", 64'(status_uflow_cnt), 64'd5);

    // source switch between ticks
    cfg_src = 2'd0; cfg_uflow_hold = 0;
    bus.s0_valid = 1; bus.s0_data = smp_a; bus.s1_valid = 1; bus.s1_data = smp_b;
    base = dac_log.size(); r0_base = r0_cnt; r1_base = r1_cnt;
    step(1);
    cfg_src = 2'd1;
    step(3);
    chk("t4_strobes", 64'(dac_log.size() - base), 64'd2);
    chk("t4_first", 64'(dac_log[base]), 64'(smp_a));
    chk("t4_second", 64'(dac_log[base + 1]), 64'(smp_b));
    chk("t4_s0_once", 64'(r0_cnt - r0_base), 64'd1);
    chk("t4_s1_once", 64'(r1_cnt - r1_base), 64'd1);

    // disable mid-period: one zero flush strobe, then idle
    step(1);
    cfg_enable = 0;
    base = dac_log.size();
    step(4);
    chk("t5_strobes", 64'(dac_log.size() - base), 64'd2);
    chk("t5_last_svc", 64'(dac_log[base]), 64'(smp_b));
    chk("t5_flush_zero", 64'(dac_log[base + 1]), 64'd0);
    chk("t5_inactive", 64'(status_active), 64'd0);
    chk("t5_readies", 64'({bus.s0_ready, bus.s1_ready}), 64'd0);

    // pattern source in one-channel mode
    cfg_src = 2'd2; cfg_r1_mode = 1; cfg_enable = 1;
    base = dac_log.size();
    step(8);
    chk("t6_strobes", 64'(dac_log.size() - base), 64'd3);
    for (int k = 0; k < 3; k++) chk("t6_pattern", 64'(dac_log[base + k]), 64'(exp_pat[k]));
    chk("t6_r1_mode", 64'(bus.dac_r1_mode), 64'd1);

    // asynchronous reset while a strobe is on the port
    step(1);
    chk("t6_mid_strobe", 64'(bus.dac_valid), 64'd1);
    rstn = 1'b0;
    #1;
    chk("rst_dac_valid", 64'(bus.dac_valid), 64'd0);
    chk("rst_data", 64'({bus.dac_data_i1, bus.dac_data_q1, bus.dac_data_i2, bus.dac_data_q2}),
        64'd0);
    chk("rst_active", 64'(status_active), 64'd0);
    chk("rst_r1_mode", 64'(bus.dac_r1_mode), 64'd0);
    cfg_src = 2'd0; bus.s0_valid = 0; cfg_r1_mode = 0;
    @(posedge clk); #1;
    rstn = 1'b1;

    // counter saturation; r1 mode change while running must be ignored
    step(10);
    cfg_r1_mode = 1;
    step(30);
    chk("sat_uflow", 64'(status_uflow_cnt), 64'(UMAX));
    chk("sat_r1_mode", 64'(bus.dac_r1_mode), 64'd0);

    cfg_enable = 0;
    step(6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
